// File: rtl/prover_round_collector_pkg.sv
// Shared types for the sumcheck round collector: slot metadata, round kinds
// and ready_code decoding.
package prover_round_collector_pkg;

  localparam logic KIND_F = 1'b0;
  localparam logic KIND_P = 1'b1;

  // Metadata fields are sized for the largest supported configuration and
  // narrowed at the collector outputs.
  localparam int META_CW = 16;
  localparam int META_RW = 32;

  localparam int CODE_FINAL_BIT = 1;

  typedef struct packed {
    logic [META_CW-1:0] count;
    logic               kind;
    logic [1:0]         code;
    logic [META_RW-1:0] rnd;
  } slot_meta_t;

  // ready_code 2'b00/2'b01 continue the sumcheck, 2'b1x is the final round.
  function automatic logic is_final(input logic [1:0] code);
    return code[CODE_FINAL_BIT];
  endfunction

endpackage

// File: rtl/prover_round_collector_round_slot_mem.sv
// Per-round word storage: nslots x npoints words, one word write port and a
// full-slot read of the head slot.
module prover_round_collector_round_slot_mem #(
  parameter int NBITS   = 64,
  parameter int NPOINTS = 8,
  parameter int NSLOTS  = 2,
  parameter int PW      = $clog2(NSLOTS),
  parameter int IW      = $clog2(NPOINTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_we,
  input  logic [PW-1:0]    i_wr_slot,
  input  logic [IW-1:0]    i_wr_idx,
  input  logic [NBITS-1:0] i_wr_data,
  input  logic [PW-1:0]    i_rd_slot,
  output logic [NBITS-1:0] o_rd_words [NPOINTS]
);

  logic [NBITS-1:0] r_mem [NSLOTS][NPOINTS];

  // Storage is zeroed so the head slot reads 0 after reset or a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NSLOTS; s++)
        for (int i = 0; i < NPOINTS; i++) r_mem[s][i] <= '0;
    end else if (i_clear) begin
      for (int s = 0; s < NSLOTS; s++)
        for (int i = 0; i < NPOINTS; i++) r_mem[s][i] <= '0;
    end else if (i_we) begin
      r_mem[i_wr_slot][i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_words = r_mem[i_rd_slot];

endmodule

// File: rtl/prover_round_collector.sv
// Collects prover-layer field words per sumcheck round into a small ring of
// slots and presents committed rounds on a valid/ready interface.
module prover_round_collector
  import prover_round_collector_pkg::*;
#(
  parameter int nbits   = 64,
  parameter int npoints = 8,
  parameter int nslots  = 2,
  parameter int nrbits  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         f_wren,
  input  logic                         p_wren,
  input  logic [nbits-1:0]             fp_data,
  input  logic                         round_done,
  input  logic [1:0]                   round_code,
  output logic                         full,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [nbits-1:0]             out_data [npoints],
  output logic [$clog2(npoints+1)-1:0] out_count,
  output logic                         out_kind,
  output logic [1:0]                   out_code,
  output logic                         out_last,
  output logic [nrbits-1:0]            out_round,
  output logic                         err_ovf,
  output logic                         err_drop,
  output logic                         err_kind
);

  localparam int CW = $clog2(npoints+1);
  localparam int PW = $clog2(nslots);
  localparam int OW = $clog2(nslots+1);
  localparam int IW = $clog2(npoints);

  logic [PW-1:0]     r_wr, r_rd;
  logic [OW-1:0]     r_occ;
  logic [CW-1:0]     r_cnt;
  logic              r_kind;
  logic [nrbits-1:0] r_rnd;
  logic              r_full, r_err_ovf, r_err_drop, r_err_kind;
  slot_meta_t        r_meta [nslots];

  logic          w_strobe, w_wr_ok, w_word, w_commit, w_pop, w_first;
  logic          w_kind_in, w_kind_cmt, w_mix, w_at_cap;
  logic [CW-1:0] w_cnt_cmt;
  logic [OW-1:0] w_occ_nxt;
  logic [PW-1:0] w_wr_nxt, w_rd_nxt;

  // While full every upstream event is dropped, even if a pop frees a slot
  // in the same cycle.
  assign w_strobe   = f_wren | p_wren;
  assign w_wr_ok    = w_strobe & ~r_full;
  assign w_at_cap   = (r_cnt == CW'(npoints));
  assign w_word     = w_wr_ok & ~w_at_cap;
  assign w_commit   = round_done & ~r_full;
  assign w_pop      = (r_occ != '0) & out_ready;
  assign w_first    = (r_cnt == '0);
  assign w_kind_in  = p_wren ? KIND_P : KIND_F;
  assign w_kind_cmt = (w_wr_ok & w_first) ? w_kind_in : r_kind;
  assign w_mix      = w_wr_ok & ((f_wren & p_wren) | (~w_first & (w_kind_in != r_kind)));
  assign w_cnt_cmt  = r_cnt + CW'(w_word);
  assign w_occ_nxt  = r_occ + OW'(w_commit) - OW'(w_pop);
  assign w_wr_nxt   = (r_wr == PW'(nslots-1)) ? '0 : r_wr + 1'b1;
  assign w_rd_nxt   = (r_rd == PW'(nslots-1)) ? '0 : r_rd + 1'b1;

  prover_round_collector_round_slot_mem #(
    .NBITS(nbits), .NPOINTS(npoints), .NSLOTS(nslots)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (clear),
    .i_we       (w_word),
    .i_wr_slot  (r_wr),
    .i_wr_idx   (IW'(r_cnt)),
    .i_wr_data  (fp_data),
    .i_rd_slot  (r_rd),
    .o_rd_words (out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0; r_rd <= '0; r_occ <= '0; r_cnt <= '0; r_kind <= KIND_F;
      r_rnd <= '0; r_full <= 1'b0;
      r_err_ovf <= 1'b0; r_err_drop <= 1'b0; r_err_kind <= 1'b0;
      for (int s = 0; s < nslots; s++) r_meta[s] <= '0;
    end else if (clear) begin
      r_wr <= '0; r_rd <= '0; r_occ <= '0; r_cnt <= '0; r_kind <= KIND_F;
      r_rnd <= '0; r_full <= 1'b0;
      r_err_ovf <= 1'b0; r_err_drop <= 1'b0; r_err_kind <= 1'b0;
      for (int s = 0; s < nslots; s++) r_meta[s] <= '0;
    end else begin
      if (w_word) r_cnt <= r_cnt + 1'b1;
      if (w_wr_ok & w_first) r_kind <= w_kind_in;
      // A word strobed alongside round_done belongs to the closing round.
      if (w_commit) begin
        r_meta[r_wr] <= '{count: META_CW'(w_cnt_cmt), kind: w_kind_cmt,
                          code: round_code, rnd: META_RW'(r_rnd)};
        r_wr   <= w_wr_nxt;
        r_rnd  <= r_rnd + 1'b1;
        r_cnt  <= '0;
        r_kind <= KIND_F;
      end
      if (w_pop) r_rd <= w_rd_nxt;
      r_occ  <= w_occ_nxt;
      r_full <= (w_occ_nxt == OW'(nslots));
      if (w_wr_ok & w_at_cap) r_err_ovf <= 1'b1;
      if (r_full & (w_strobe | round_done)) r_err_drop <= 1'b1;
      if (w_mix) r_err_kind <= 1'b1;
    end
  end

  assign full      = r_full;
  assign out_valid = (r_occ != '0);
  assign out_count = CW'(r_meta[r_rd].count);
  assign out_kind  = r_meta[r_rd].kind;
  assign out_code  = r_meta[r_rd].code;
  assign out_last  = is_final(r_meta[r_rd].code);
  assign out_round = nrbits'(r_meta[r_rd].rnd);
  assign err_ovf   = r_err_ovf;
  assign err_drop  = r_err_drop;
  assign err_kind  = r_err_kind;

endmodule

// File: tb/tb_prover_round_collector.sv
// Self-checking bench for prover_round_collector: a scoreboard of expected
// rounds is filled as rounds are closed and compared when the head is popped.
module tb_prover_round_collector;

  localparam int NB = 64;
  localparam int NP = 8;
  localparam int NS = 2;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst, clear, f_wren, p_wren, round_done, out_ready;
  logic [NB-1:0] fp_data;
  logic [1:0]    round_code, out_code;
  logic          full, out_valid, out_kind, out_last, err_ovf, err_drop, err_kind;
  logic [NB-1:0] out_data [NP];
  logic [3:0]    out_count;
  logic [NR-1:0] out_round;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int            cnt;
    logic          kind;
    logic [1:0]    code;
    logic [NR-1:0] rnd;
    logic [NB-1:0] w [NP];
  } exp_t;

  exp_t          sb[$];
  int            m_cnt;
  logic          m_kind;
  logic [NR-1:0] m_rnd;
  logic [NB-1:0] m_w [NP];

  prover_round_collector #(.nbits(NB), .npoints(NP), .nslots(NS), .nrbits(NR)) dut (
    .clk(clk), .rst(rst), .clear(clear), .f_wren(f_wren), .p_wren(p_wren),
    .fp_data(fp_data), .round_done(round_done), .round_code(round_code),
    .full(full), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_kind(out_kind), .out_code(out_code),
    .out_last(out_last), .out_round(out_round), .err_ovf(err_ovf),
    .err_drop(err_drop), .err_kind(err_kind)
  );

  always #5 clk = ~clk;

  // Scoreboard compare happens on the falling edge before a popping edge.
  task automatic tick();
    exp_t e;
    bit   bad;
    int   bi;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      checks += 2;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got round=%0d, required no pending round", out_round);
      end else begin
        e = sb.pop_front();
        if (out_count !== 4'(e.cnt) || out_kind !== e.kind || out_code !== e.code ||
            out_last !== e.code[1] || out_round !== e.rnd) begin
          errors++;
          $display("FAIL pop_meta: got cnt=%0d kind=%0d code=%0d last=%0d rnd=%0d, required cnt=%0d kind=%0d code=%0d last=%0d rnd=%0d",
                   out_count, out_kind, out_code, out_last, out_round,
                   e.cnt, e.kind, e.code, e.code[1], e.rnd);
        end
        bad = 0; bi = 0;
        for (int i = 0; i < e.cnt; i++)
          if (!bad && out_data[i] !== e.w[i]) begin bad = 1; bi = i; end
        if (bad) begin
          errors++;
          $display("FAIL pop_data: word[%0d] got %h, required %h", bi, out_data[bi], e.w[bi]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic m_word(input logic k, input logic [NB-1:0] d);
    if (m_cnt == 0) m_kind = k;
    if (m_cnt < NP) begin m_w[m_cnt] = d; m_cnt++; end
  endtask

  task automatic m_close(input logic [1:0] c);
    exp_t e;
    e.cnt  = m_cnt;
    e.kind = (m_cnt == 0) ? 1'b0 : m_kind;
    e.code = c;
    e.rnd  = m_rnd;
    e.w    = m_w;
    sb.push_back(e);
    m_rnd++;
    m_cnt = 0;
  endtask

  task automatic m_reset();
    sb.delete();
    m_cnt = 0; m_kind = 0; m_rnd = '0;
  endtask

  task automatic wr(input logic f, input logic p, input logic [NB-1:0] d);
    f_wren = f; p_wren = p; fp_data = d;
    m_word(p, d);
    tick();
    f_wren = 0; p_wren = 0;
  endtask

  task automatic close(input logic [1:0] c);
    round_done = 1; round_code = c;
    m_close(c);
    tick();
    round_done = 0;
  endtask

  task automatic pop1();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    #3;
    checks++;
    if ({out_valid, full, out_kind, out_last, err_ovf, err_drop, err_kind} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b, required 0000000",
        {out_valid, full, out_kind, out_last, err_ovf, err_drop, err_kind});
    end
    checks++;
    if (out_count !== 4'd0 || out_round !== 8'd0 || out_code !== 2'd0) begin
      errors++; $display("FAIL reset_fields: got cnt=%0d rnd=%0d code=%0d, required 0", out_count, out_round, out_code);
    end
    checks++;
    if (out_data[0] !== 64'd0) begin
      errors++; $display("FAIL reset_data: got %h, required 0", out_data[0]);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_basic();
    wr(0, 1, 64'h11); wr(0, 1, 64'h22); wr(0, 1, 64'h33);
    close(2'b01);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 4'd3 || out_kind !== 1'b1 || out_data[2] !== 64'h33) begin
      errors++; $display("FAIL basic_visible: got v=%0d cnt=%0d kind=%0d w2=%h, required v=1 cnt=3 kind=1 w2=33",
        out_valid, out_count, out_kind, out_data[2]);
    end
    pop1();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drained: got out_valid=%0d, required 0", out_valid);
    end
  endtask

  task automatic test_full();
    wr(1, 0, 64'h5); close(2'b00);
    wr(0, 1, 64'h6); wr(0, 1, 64'h7); close(2'b00);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %0d, required 1", full); end
    f_wren = 1; fp_data = 64'hDEAD; round_done = 1; round_code = 2'b11;
    tick();
    f_wren = 0; round_done = 0;
    checks++;
    if (err_drop !== 1'b1 || full !== 1'b1) begin
      errors++; $display("FAIL full_drop: got err_drop=%0d full=%0d, required 1 1", err_drop, full);
    end
    // Strobe during the popping cycle must still be dropped.
    out_ready = 1; p_wren = 1; fp_data = 64'hBEEF;
    tick();
    out_ready = 0; p_wren = 0;
    checks++;
    if (full !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL full_release: got full=%0d v=%0d, required 0 1", full, out_valid);
    end
    pop1();
  endtask

  task automatic test_ovf();
    for (int i = 1; i <= 9; i++) wr(1, 0, 64'(i * 'h101));
    checks++;
    if (err_ovf !== 1'b1 || err_kind !== 1'b0) begin
      errors++; $display("FAIL ovf_flag: got ovf=%0d kind=%0d, required 1 0", err_ovf, err_kind);
    end
    close(2'b00);
    pop1();
  endtask

  task automatic test_coincident();
    wr(0, 1, 64'h5); close(2'b01);
    wr(1, 0, 64'h9);
    f_wren = 1; fp_data = 64'hAA; round_done = 1; round_code = 2'b00; out_ready = 1;
    m_word(0, 64'hAA); m_close(2'b00);
    tick();
    f_wren = 0; round_done = 0; out_ready = 0;
    checks++;
    if (out_valid !== 1'b1 || full !== 1'b0 || out_count !== 4'd2 || out_data[1] !== 64'hAA) begin
      errors++; $display("FAIL coincident: got v=%0d full=%0d cnt=%0d w1=%h, required 1 0 2 aa",
        out_valid, full, out_count, out_data[1]);
    end
    pop1();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL commit_pop_occ: got out_valid=%0d, required 0", out_valid);
    end
  endtask

  task automatic test_last();
    wr(0, 1, 64'h1234); close(2'b10);
    checks++;
    if (out_last !== 1'b1 || out_code !== 2'b10) begin
      errors++; $display("FAIL last: got last=%0d code=%0d, required 1 2", out_last, out_code);
    end
    pop1();
  endtask

  task automatic test_kind();
    wr(1, 1, 64'h77);
    checks++;
    if (err_kind !== 1'b1) begin errors++; $display("FAIL kind_both: got %0d, required 1", err_kind); end
    wr(1, 0, 64'h78);
    close(2'b00);
    pop1();
  endtask

  task automatic test_wrap();
    logic [NR-1:0] r;
    out_ready = 1;
    for (int i = 0; i < (1 << NR) + 1; i++) begin
      r = m_rnd;
      close(2'b00);
      if (r <= 8'd1) begin
        checks++;
        if (out_round !== r) begin
          errors++; $display("FAIL wrap_round: got %0d, required %0d", out_round, r);
        end
      end
    end
    tick();
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: got v=%0d, required 0", out_valid); end
  endtask

  task automatic test_clear();
    wr(1, 0, 64'h1); close(2'b00);
    wr(1, 0, 64'h2); close(2'b00);
    checks++;
    if ({full, err_ovf, err_drop, err_kind} !== 4'b1111) begin
      errors++; $display("FAIL clear_pre: got %b, required 1111", {full, err_ovf, err_drop, err_kind});
    end
    clear = 1;
    tick();
    clear = 0;
    m_reset();
    checks++;
    if ({out_valid, full, err_ovf, err_drop, err_kind} !== 5'b0) begin
      errors++; $display("FAIL clear_post: got %b, required 00000", {out_valid, full, err_ovf, err_drop, err_kind});
    end
    wr(0, 1, 64'h55); close(2'b00);
    checks++;
    if (out_round !== 8'd0) begin errors++; $display("FAIL clear_round: got %0d, required 0", out_round); end
    pop1();
  endtask

  task automatic test_rst_async();
    wr(1, 0, 64'h66); close(2'b00);
    wr(1, 0, 64'h67);
    #2 rst = 1;
    #1;
    checks++;
    if ({out_valid, full} !== 2'b0 || out_count !== 4'd0 || out_data[0] !== 64'd0) begin
      errors++; $display("FAIL rst_async: got v=%0d full=%0d cnt=%0d w0=%h, required all 0",
        out_valid, full, out_count, out_data[0]);
    end
    #1 rst = 0;
    m_reset();
    tick();
    wr(0, 1, 64'h77); close(2'b00);
    pop1();
  endtask

  initial begin
    rst = 1; clear = 0; f_wren = 0; p_wren = 0; fp_data = '0;
    round_done = 0; round_code = '0; out_ready = 0;
    m_cnt = 0; m_kind = 0; m_rnd = '0;
    test_reset();
    test_basic();
    test_full();
    test_ovf();
    test_coincident();
    test_last();
    test_kind();
    test_wrap();
    test_clear();
    test_rst_async();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_empty: got %0d pending rounds, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
